jtag_host: RTL

JTAG_HOST -- requirements
Module: jtag_host

---
 rtl/jtag_host.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_host.sv
`timescale 1ns/1ps
// JTAG host: TAP reset, 4-bit IR scan and 1..32-bit DR scan over a divided TCK.
// Define JTAG_HOST_TRST_EN to pulse trst_n low for 2 TCKs at the start of TAP reset.
module jtag_host #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic [31:0] rsp_data,
   output logic        done,
   output logic        tck,
   output logic        tms,
   output logic        tdi,
   output logic        trst_n,
   input  logic        tdo
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
`ifdef JTAG_HOST_TRST_EN
   localparam logic [5:0] RST_LAST  = 6'd7;
   localparam logic [5:0] TRST_BITS = 6'd2;
`else
   localparam logic [5:0] RST_LAST  = 6'd5;
`endif

   // Each non-idle state names where the TAP sits during that TCK.
   typedef enum logic [3:0] {
      IDLE, RST_SEQ, RTI, SEL_DR, SEL_IR,
      CAPTURE, SHIFT, EXIT1, UPDATE
   } state_e;

   state_e      state_q, state_d;
   logic        ir_q, ir_d;
   logic [4:0]  len_q, len_d;
   logic [31:0] data_q, data_d;
   logic [31:0] rsp_q, rsp_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [7:0]  div_q, div_d;
   logic        tck_q, tck_d;
   logic        tms_q, tms_d;
   logic        tdi_q, tdi_d;
   logic        done_q, done_d;
   logic        rdy_q, rdy_d;
   logic        launch;
   logic [5:0]  shift_last;
`ifdef JTAG_HOST_TRST_EN
   logic        trst_q, trst_d;
`endif

   assign shift_last = ir_q ? 6'd3 : {1'b0, len_q};

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      len_d   = len_q;
      data_d  = data_q;
      rsp_d   = rsp_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      tck_d   = tck_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      done_d  = 1'b0;
      launch  = 1'b0;
`ifdef JTAG_HOST_TRST_EN
      trst_d  = trst_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && rdy_q) begin
               ir_d   = (cmd_op == 2'b01);
               len_d  = cmd_len;
               data_d = cmd_data;
               rsp_d  = '0;
               cnt_d  = '0;
               div_d  = '0;
               unique case (cmd_op)
                  2'b00: begin
                     state_d = RST_SEQ;
                     launch  = 1'b1;
                  end
                  2'b01, 2'b10: begin
                     state_d = RTI;
                     launch  = 1'b1;
                  end
                  default: done_d = 1'b1;
               endcase
            end
         end
         default: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = '0;
               tck_d = !tck_q;
               if (!tck_q) begin
                  // tdo is sampled on the edge that raises tck
                  if (state_q == SHIFT)
                     rsp_d[cnt_q[4:0]] = tdo;
               end else begin
                  unique case (state_q)
                     RST_SEQ: begin
                        if (cnt_q == RST_LAST) state_d = IDLE;
                        else cnt_d = cnt_q + 6'd1;
                     end
                     RTI:     state_d = SEL_DR;
                     SEL_DR:  state_d = ir_q ? SEL_IR : CAPTURE;
                     SEL_IR:  state_d = CAPTURE;
                     CAPTURE: begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                     end
                     SHIFT: begin
                        if (cnt_q == shift_last) state_d = EXIT1;
                        else cnt_d = cnt_q + 6'd1;
                     end
                     EXIT1:   state_d = UPDATE;
                     default: state_d = IDLE;
                  endcase
                  if (state_d == IDLE) done_d = 1'b1;
                  else launch = 1'b1;
               end
            end
         end
      endcase

      // New tms/tdi only at the start of a tck-low phase
      if (launch) begin
         tdi_d = 1'b0;
         unique case (state_d)
            RST_SEQ: tms_d = (cnt_d != RST_LAST);
            RTI:     tms_d = 1'b1;
            SEL_DR:  tms_d = ir_q;
            SEL_IR:  tms_d = 1'b0;
            CAPTURE: tms_d = 1'b0;
            SHIFT: begin
               tms_d = (cnt_d == shift_last);
               tdi_d = data_q[cnt_d[4:0]];
            end
            EXIT1:   tms_d = 1'b1;
            default: tms_d = 1'b0;
         endcase
`ifdef JTAG_HOST_TRST_EN
         trst_d = (state_d != RST_SEQ) || (cnt_d >= TRST_BITS);
`endif
      end
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ir_q    <= 1'b0;
         len_q   <= '0;
         data_q  <= '0;
         rsp_q   <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         tck_q   <= 1'b0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         len_q   <= len_d;
         data_q  <= data_d;
         rsp_q   <= rsp_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         tck_q   <= tck_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
      end
   end

`ifdef JTAG_HOST_TRST_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) trst_q <= 1'b1;
      else       trst_q <= trst_d;
   end
   assign trst_n = trst_q;
`else
   assign trst_n = 1'b1;
`endif

   assign cmd_ready = rdy_q;
   assign rsp_data  = rsp_q;
   assign done      = done_q;
   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;

endmodule
